fpu_issue: RTL and testbench

CPU-side initiator for the FPU: accepts floating-point instructions from decode, tracks pending destination registers in a scoreboard, stalls on hazards, divider-busy and result-buffer credit, and drives the FPU request port with registered outputs. Results returned by the FPU, which cannot be back-pressured, are buffered in a small FIFO and presented to the register-file write arbiter with a valid/ready handshake.

---
 rtl/fpu_pkg.sv | 27 ++
 rtl/fpu_result_fifo.sv | 49 ++++
 rtl/fpu_issue.sv | 120 ++++++++++++
 tb/tb_fpu_issue.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU opcode definitions and result-buffer entry layout.
// Used by the issue block and by instruction decode.
package fpu_pkg;

  localparam logic [3:0] FPU_ADD = 4'h8;
  localparam logic [3:0] FPU_SUB = 4'h9;
  localparam logic [3:0] FPU_MUL = 4'hA;
  localparam logic [3:0] FPU_DIV = 4'hB;
  localparam logic [3:0] FPU_CMP = 4'hD;
  localparam logic [3:0] FPU_I2F = 4'hE;
  localparam logic [3:0] FPU_F2I = 4'hF;

  localparam int RES_W = 37;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } fpu_res_t;

  function automatic logic fpu_op_legal(input logic [3:0] op);
    case (op)
      FPU_ADD, FPU_SUB, FPU_MUL, FPU_DIV, FPU_CMP, FPU_I2F, FPU_F2I: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Synchronous FIFO holding FPU results until the register-file write port takes them.
// Pushes while full and pops while empty are ignored.
module fpu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fpu_issue.sv
// FPU issue stage: destination scoreboard, hazard/credit stall, registered FPU request,
// and buffered write-back of results that the FPU delivers without back-pressure.
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [3:0]  issue_op,
  input  logic [4:0]  issue_src_a,
  input  logic [4:0]  issue_src_b,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [4:0]  issue_dest,
  output logic        issue_stall,
  output logic        issue_illegal,
  output logic [3:0]  fpu_op,
  output logic [31:0] fpu_in_a,
  output logic [31:0] fpu_in_b,
  output logic [4:0]  fpu_in_dest,
  input  logic        fpu_valid,
  input  logic [4:0]  fpu_dest,
  input  logic [31:0] fpu_result,
  input  logic        fpu_div_busy,
  output logic        wb_valid,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  input  logic        wb_ready,
  output logic [31:0] scoreboard,
  output logic        err_overflow,
  output logic        err_spurious
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   sb_q;
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          credit_out;
  logic          hazard;
  logic          accept;
  logic          illegal_now;
  logic          res_take;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic [31:0]   sb_set;
  logic [31:0]   sb_clr;
  fpu_res_t      push_ent;
  fpu_res_t      head_ent;

  // Credit counts results already owed by the FPU plus those buffered, so a
  // result can never arrive to a full buffer. A same-cycle pop is not counted.
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign credit_out  = (credit_used >= (CW+1)'(FIFO_DEPTH));

  assign hazard = sb_q[issue_src_a] | sb_q[issue_src_b] | sb_q[issue_dest]
                | ((issue_op == FPU_DIV) & fpu_div_busy) | credit_out;

  assign issue_stall = issue_valid & hazard;
  assign accept      = issue_valid & ~hazard & fpu_op_legal(issue_op);
  assign illegal_now = issue_valid & ~hazard & ~fpu_op_legal(issue_op);

  assign res_take = fpu_valid & (inflight_q != '0);
  assign wb_valid = ~fifo_empty;
  assign pop      = wb_valid & wb_ready;

  assign sb_set = (accept && issue_dest != 5'd0) ? (32'd1 << issue_dest) : 32'd0;
  assign sb_clr = (pop && wb_dest != 5'd0)       ? (32'd1 << wb_dest)    : 32'd0;

  assign push_ent = '{dest: fpu_dest, data: fpu_result};
  assign wb_dest  = head_ent.dest;
  assign wb_data  = head_ent.data;
  assign scoreboard = sb_q;

  fpu_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (res_take),
    .push_data (push_ent),
    .pop       (pop),
    .pop_data  (head_ent),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      sb_q          <= '0;
      inflight_q    <= '0;
      fpu_op        <= '0;
      fpu_in_a      <= '0;
      fpu_in_b      <= '0;
      fpu_in_dest   <= '0;
      issue_illegal <= 1'b0;
      err_overflow  <= 1'b0;
      err_spurious  <= 1'b0;
    end else begin
      sb_q          <= (sb_q & ~sb_clr) | sb_set;
      inflight_q    <= inflight_q + CW'(accept) - CW'(res_take);
      fpu_op        <= accept ? issue_op : 4'd0;
      issue_illegal <= illegal_now;
      if (accept) begin
        fpu_in_a    <= issue_a;
        fpu_in_b    <= issue_b;
        fpu_in_dest <= issue_dest;
      end
      err_spurious  <= err_spurious | (fpu_valid & (inflight_q == '0));
      err_overflow  <= err_overflow | (res_take & fifo_full);
    end
  end

endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue: reference model of the issue rules plus a stand-in FPU that
// returns results out of order; request and write-back monitors drain expectation queues.
module tb_fpu_issue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_op = '0;
  logic [4:0]  issue_src_a = '0, issue_src_b = '0, issue_dest = '0;
  logic [31:0] issue_a = '0, issue_b = '0;
  logic        issue_stall, issue_illegal;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_in_a, fpu_in_b;
  logic [4:0]  fpu_in_dest;
  logic        fpu_valid = 1'b0;
  logic [4:0]  fpu_dest = '0;
  logic [31:0] fpu_result = '0;
  logic        fpu_div_busy = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        wb_ready = 1'b1;
  logic [31:0] scoreboard;
  logic        err_overflow, err_spurious;

  fpu_issue #(.FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_src_a(issue_src_a), .issue_src_b(issue_src_b),
    .issue_a(issue_a), .issue_b(issue_b), .issue_dest(issue_dest),
    .issue_stall(issue_stall), .issue_illegal(issue_illegal),
    .fpu_op(fpu_op), .fpu_in_a(fpu_in_a), .fpu_in_b(fpu_in_b), .fpu_in_dest(fpu_in_dest),
    .fpu_valid(fpu_valid), .fpu_dest(fpu_dest), .fpu_result(fpu_result),
    .fpu_div_busy(fpu_div_busy),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .wb_ready(wb_ready),
    .scoreboard(scoreboard), .err_overflow(err_overflow), .err_spurious(err_spurious)
  );

  always #5 clock = ~clock;

  typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [4:0] dest; } req_t;
  typedef struct { logic [4:0] dest; logic [31:0] data; } res_t;

  req_t exp_req[$];
  res_t exp_wb[$];
  res_t mdl_fifo[$];
  req_t fpu_pend[$];

  logic [31:0] pend_m = '0;
  int          infl_m = 0;
  bit          spur_m = 0;
  bit          ill_m = 0;
  bit          last_acc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [3:0] legal_ops [7] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE, 4'hF};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name, input int lim);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: condition not reached within %0d cycles", name, lim);
  endtask

  // One clock cycle: called at a falling edge with inputs already driven.
  task automatic step();
    bit   stall, legal, acc, take;
    res_t r;
    req_t q;
    #1;
    q = '{4'h0, 32'h0, 32'h0, 5'h0};
    if (reset) begin
      pend_m = '0; infl_m = 0; spur_m = 0; ill_m = 0; last_acc = 0;
      mdl_fifo.delete(); exp_wb.delete(); exp_req.delete();
      exp_req.push_back(q);
    end else begin
      stall = issue_valid && (pend_m[issue_src_a] || pend_m[issue_src_b] || pend_m[issue_dest]
              || (issue_op == 4'hB && fpu_div_busy) || (infl_m + mdl_fifo.size() >= DEPTH));
      chk("issue_stall", issue_stall, stall);
      chk("scoreboard", scoreboard, pend_m);
      chk("wb_valid", wb_valid, mdl_fifo.size() != 0);
      chk("issue_illegal", issue_illegal, ill_m);
      chk("err_spurious", err_spurious, spur_m);
      chk("err_overflow", err_overflow, 0);
      legal = (issue_op inside {4'h8, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE, 4'hF});
      acc   = issue_valid && !stall && legal;
      ill_m = issue_valid && !stall && !legal;
      if (mdl_fifo.size() != 0 && wb_ready) begin
        r = mdl_fifo.pop_front();
        if (r.dest != 0) pend_m[r.dest] = 1'b0;
      end
      take = 0;
      if (fpu_valid) begin
        if (infl_m == 0) spur_m = 1;
        else begin
          take = 1;
          r = '{fpu_dest, fpu_result};
          mdl_fifo.push_back(r);
          exp_wb.push_back(r);
        end
      end
      if (acc) begin
        if (issue_dest != 0) pend_m[issue_dest] = 1'b1;
        q = '{issue_op, issue_a, issue_b, issue_dest};
        fpu_pend.push_back(q);
      end
      exp_req.push_back(q);
      infl_m = infl_m + int'(acc) - int'(take);
      last_acc = acc;
    end
    @(negedge clock);
    fpu_valid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] sa, input logic [4:0] sb,
                       input logic [4:0] d, input logic [31:0] a, input logic [31:0] b);
    issue_valid = 1'b1; issue_op = op; issue_src_a = sa; issue_src_b = sb;
    issue_dest = d; issue_a = a; issue_b = b;
  endtask

  task automatic ret_idx(input int idx, input logic [31:0] res);
    fpu_valid = 1'b1;
    fpu_dest = fpu_pend[idx].dest;
    fpu_result = res;
    fpu_pend.delete(idx);
  endtask

  task automatic ret_dest(input logic [4:0] d, input logic [31:0] res);
    int idx = -1;
    foreach (fpu_pend[i]) if (idx < 0 && fpu_pend[i].dest == d) idx = i;
    if (idx < 0) bound_fail("ret_dest_missing", 0);
    else ret_idx(idx, res);
  endtask

  task automatic hold_until_accept(input string name, input int lim, output int n);
    n = 0;
    for (int i = 0; i < lim; i++) begin
      n++;
      step();
      if (last_acc) begin
        issue_valid = 1'b0;
        return;
      end
    end
    issue_valid = 1'b0;
    bound_fail(name, lim);
  endtask

  task automatic drain();
    issue_valid = 1'b0; wb_ready = 1'b1; fpu_div_busy = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (fpu_pend.size() == 0 && mdl_fifo.size() == 0 && infl_m == 0) return;
      if (fpu_pend.size() != 0) ret_idx(0, fpu_pend[0].a + fpu_pend[0].b);
      step();
    end
    bound_fail("drain", 60);
  endtask

  always @(negedge clock) begin : mon_req
    req_t q;
    if (exp_req.size() != 0) begin
      q = exp_req.pop_front();
      chk("fpu_op", fpu_op, q.op);
      if (q.op != 0) begin
        chk("fpu_in_a", fpu_in_a, q.a);
        chk("fpu_in_b", fpu_in_b, q.b);
        chk("fpu_in_dest", fpu_in_dest, q.dest);
      end
    end
  end

  always @(posedge clock) begin : mon_wb
    res_t r;
    if (reset === 1'b0 && wb_valid === 1'b1 && wb_ready === 1'b1) begin
      if (exp_wb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL wb_unexpected: got dest %0d data %0h expected no write-back", wb_dest, wb_data);
      end else begin
        r = exp_wb.pop_front();
        chk("wb_dest", wb_dest, r.dest);
        chk("wb_data", wb_data, r.data);
      end
    end
  end

  initial begin
    int n;
    @(negedge clock);
    step();
    reset = 1'b0;
    chk("rst_fpu_op", fpu_op, 0);
    chk("rst_fpu_in_a", fpu_in_a, 0);
    chk("rst_fpu_in_b", fpu_in_b, 0);
    chk("rst_fpu_in_dest", fpu_in_dest, 0);
    chk("rst_scoreboard", scoreboard, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_illegal", issue_illegal, 0);
    chk("rst_errs", {err_overflow, err_spurious}, 0);

    // add r3 = r1 + r2
    issue(4'h8, 5'd1, 5'd2, 5'd3, 32'h3F800000, 32'h40000000);
    step();
    issue_valid = 1'b0;
    chk("add_sb3_set", scoreboard[3], 1);
    ret_dest(5'd3, 32'h40400000);
    step();
    chk("add_wb_valid", wb_valid, 1);
    chk("add_wb_data", wb_data, 32'h40400000);
    step();
    chk("add_sb3_clear", scoreboard[3], 0);

    // RAW on r5
    issue(4'hA, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22);
    step();
    issue(4'h8, 5'd5, 5'd2, 5'd6, 32'h33, 32'h44);
    step();
    step();
    ret_dest(5'd5, 32'h40A00000);
    step();
    hold_until_accept("raw_accept", 6, n);
    chk("raw_latency", n, 2);
    drain();

    // divide held off by a busy divider
    fpu_div_busy = 1'b1;
    issue(4'hB, 5'd1, 5'd2, 5'd7, 32'h5, 32'h6);
    step(); step(); step();
    fpu_div_busy = 1'b0;
    hold_until_accept("div_accept", 4, n);
    chk("div_latency", n, 1);
    drain();

    // result-buffer credit
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(legal_ops[i], 5'd0, 5'd0, 5'(10 + i), $urandom, $urandom);
      step();
    end
    issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ret_dest(5'(10 + i), 32'(100 + i));
      step();
    end
    issue(4'h9, 5'd0, 5'd0, 5'd14, 32'h7, 32'h8);
    #1 chk("credit_stall", issue_stall, 1);
    step();
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    hold_until_accept("credit_accept", 4, n);
    chk("credit_latency", n, 1);
    drain();

    // reserved opcode
    issue(4'h3, 5'd1, 5'd2, 5'd9, 32'h1, 32'h2);
    step();
    issue_valid = 1'b0;
    chk("illegal_pulse", issue_illegal, 1);
    chk("illegal_sb", scoreboard, 0);
    step();
    chk("illegal_once", issue_illegal, 0);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 7))
                                              : legal_ops[$urandom_range(0, 6)];
      issue_src_a = 5'($urandom_range(0, 7));
      issue_src_b = 5'($urandom_range(0, 7));
      issue_dest = 5'($urandom_range(0, 7));
      issue_a = $urandom;
      issue_b = $urandom;
      fpu_div_busy = ($urandom_range(0, 3) == 0);
      wb_ready = ($urandom_range(0, 2) != 0);
      if (fpu_pend.size() != 0 && $urandom_range(0, 1) == 1) begin
        n = $urandom_range(0, fpu_pend.size() - 1);
        ret_idx(n, fpu_pend[n].a + fpu_pend[n].b);
      end
      step();
    end
    drain();

    // reset with two operations outstanding
    issue(4'h8, 5'd1, 5'd2, 5'd20, 32'h1, 32'h2);
    step();
    issue(4'hA, 5'd1, 5'd2, 5'd21, 32'h3, 32'h4);
    step();
    issue_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_scoreboard", scoreboard, 0);
    ret_dest(5'd20, 32'h1234);
    step();
    step();
    chk("spurious_flag", err_spurious, 1);
    chk("spurious_no_wb", wb_valid, 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
